// File: rtl/bsg_mem_pkg.sv
// Shared types for the 1r1w synchronous memory family.
package bsg_mem_pkg;

   typedef enum logic {read_old = 1'b0, write_first = 1'b1} rw_mode_e;

   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_e;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync_mask_write_bit_synth.sv
// Storage array: bit-masked synchronous write, registered read that holds when idle.
module bsg_mem_1r1w_sync_mask_write_bit_synth
   import bsg_mem_pkg::*;
#(
   parameter int width_p       = 32,
   parameter int els_p         = 16,
   parameter int addr_width_lp = safe_clog2(els_p)
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [width_p-1:0]       w_mask_i,
   input  logic                     r_v_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o
);

   logic [width_p-1:0] r_mem [els_p];
   logic [width_p-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (w_v_i)
         r_mem[w_addr_i] <= (r_mem[w_addr_i] & ~w_mask_i) | (w_data_i & w_mask_i);
   end

   // Read samples the array before this edge's write lands, so it always sees the old word.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_rdata <= '0;
      else if (r_v_i)
         r_rdata <= r_mem[r_addr_i];
   end

   assign r_data_o = r_rdata;

endmodule

// File: rtl/bsg_mem_1r1w_sync_init_bypass.sv
// 1r1w synchronous memory with post-reset zero fill, lane write mask and
// optional write-first forwarding on same-address read/write.
module bsg_mem_1r1w_sync_init_bypass
   import bsg_mem_pkg::*;
#(
   parameter int width_p       = 32,
   parameter int els_p         = 16,
   parameter int mask_width_p  = 4,
   parameter int rw_mode_p     = 1,
   parameter int init_p        = 1,
   parameter int addr_width_lp = safe_clog2(els_p)
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [mask_width_p-1:0]  w_mask_i,
   input  logic                     r_v_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o,
   output logic                     init_done_o,
   output logic                     collision_o
);

   localparam int                       lane_w_lp = width_p / mask_width_p;
   localparam logic [addr_width_lp:0]   els_lp    = (addr_width_lp+1)'(els_p);
   localparam logic [addr_width_lp-1:0] last_lp   = addr_width_lp'(els_p - 1);

   state_e                   r_state;
   logic [addr_width_lp-1:0] r_init_cnt;
   logic                     r_fwd, r_zero, r_coll;
   logic [width_p-1:0]       r_fdata, r_fmask;

   logic                     w_ready, w_w_in, w_r_in, w_same;
   logic                     w_mem_wv, w_mem_rv;
   logic [addr_width_lp-1:0] w_mem_waddr;
   logic [width_p-1:0]       w_lane_bits, w_mem_wdata, w_mem_wmask, w_mem_rdata;

   assign w_ready = (r_state == READY);
   assign w_w_in  = {1'b0, w_addr_i} < els_lp;
   assign w_r_in  = {1'b0, r_addr_i} < els_lp;
   assign w_same  = (w_addr_i == r_addr_i);

   genvar k;
   generate
      for (k = 0; k < mask_width_p; k++) begin : g_lane
         assign w_lane_bits[k*lane_w_lp +: lane_w_lp] = {lane_w_lp{w_mask_i[k]}};
      end
   endgenerate

   // While filling, the write port is owned by the init counter.
   assign w_mem_wv    = ~reset_i & (~w_ready | (w_v_i & w_w_in));
   assign w_mem_waddr = w_ready ? w_addr_i    : r_init_cnt;
   assign w_mem_wdata = w_ready ? w_data_i    : '0;
   assign w_mem_wmask = w_ready ? w_lane_bits : '1;
   assign w_mem_rv    = ~reset_i & w_ready & r_v_i & w_r_in;

   bsg_mem_1r1w_sync_mask_write_bit_synth #(
      .width_p       (width_p),
      .els_p         (els_p),
      .addr_width_lp (addr_width_lp)
   ) mem (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .w_v_i    (w_mem_wv),
      .w_addr_i (w_mem_waddr),
      .w_data_i (w_mem_wdata),
      .w_mask_i (w_mem_wmask),
      .r_v_i    (w_mem_rv),
      .r_addr_i (r_addr_i),
      .r_data_o (w_mem_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= (init_p != 0) ? INIT : READY;
         r_init_cnt <= '0;
         r_fwd      <= 1'b0;
         r_zero     <= 1'b0;
         r_coll     <= 1'b0;
         r_fdata    <= '0;
         r_fmask    <= '0;
      end else begin
         r_coll <= w_ready & w_v_i & r_v_i & w_same;
         if (!w_ready) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == last_lp)
               r_state <= READY;
         end else if (r_v_i) begin
            // Forward state is captured only on accepted reads so r_data_o holds between reads.
            r_zero  <= ~w_r_in;
            r_fwd   <= (rw_mode_p == int'(write_first)) & w_v_i & w_w_in & w_same;
            r_fdata <= w_data_i;
            r_fmask <= w_lane_bits;
         end
      end
   end

   assign r_data_o    = r_zero ? '0
                      : r_fwd  ? ((w_mem_rdata & ~r_fmask) | (r_fdata & r_fmask))
                      : w_mem_rdata;
   assign init_done_o = w_ready;
   assign collision_o = r_coll;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!reset_i && w_ready) begin
         if (w_v_i && !w_w_in) $error("bsg_mem: write address %0d out of range", w_addr_i);
         if (r_v_i && !w_r_in) $error("bsg_mem: read address %0d out of range", r_addr_i);
      end
   end
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_init_bypass.sv
// Directed plus random checks of both read/write modes against an array-level model.
module tb_bsg_mem_1r1w_sync_init_bypass;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        w_v_i, r_v_i;
   logic [3:0]  w_addr_i, r_addr_i, w_mask_i;
   logic [31:0] w_data_i;
   logic [31:0] rd_wf, rd_ro;
   logic        done_wf, done_ro, coll_wf, coll_ro;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_mem [16];
   int          m_left;
   bit          m_ready;
   logic [31:0] m_rd_wf, m_rd_ro;
   bit          m_coll;

   always #5 clk = ~clk;

   bsg_mem_1r1w_sync_init_bypass #(
      .width_p(32), .els_p(16), .mask_width_p(4), .rw_mode_p(1), .init_p(1)
   ) dut_wf (
      .clk_i(clk), .reset_i(reset_i),
      .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
      .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_data_o(rd_wf),
      .init_done_o(done_wf), .collision_o(coll_wf)
   );

   bsg_mem_1r1w_sync_init_bypass #(
      .width_p(32), .els_p(16), .mask_width_p(4), .rw_mode_p(0), .init_p(1)
   ) dut_ro (
      .clk_i(clk), .reset_i(reset_i),
      .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
      .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_data_o(rd_ro),
      .init_done_o(done_ro), .collision_o(coll_ro)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++)
         if (m[b]) res[8*b +: 8] = nw[8*b +: 8];
      return res;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: snapshot inputs, advance, update the model, compare every output.
   task automatic cyc();
      logic        s_rst, s_wv, s_rv;
      logic [3:0]  s_wa, s_ra, s_m;
      logic [31:0] s_wd, old;
      s_rst = reset_i; s_wv = w_v_i; s_rv = r_v_i;
      s_wa = w_addr_i; s_ra = r_addr_i; s_m = w_mask_i; s_wd = w_data_i;
      @(posedge clk); #1;
      if (s_rst) begin
         m_ready = 0; m_left = 16; m_rd_wf = '0; m_rd_ro = '0; m_coll = 0;
      end else if (!m_ready) begin
         m_coll = 0;
         m_left--;
         if (m_left == 0) begin
            m_ready = 1;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end else begin
         m_coll = s_wv && s_rv && (s_wa == s_ra);
         old = m_mem[s_ra];
         if (s_wv) m_mem[s_wa] = merge(m_mem[s_wa], s_wd, s_m);
         if (s_rv) begin
            m_rd_wf = m_mem[s_ra];
            m_rd_ro = old;
         end
      end
      chk("done_wf", done_wf, m_ready);
      chk("done_ro", done_ro, m_ready);
      chk("coll_wf", coll_wf, m_coll);
      chk("coll_ro", coll_ro, m_coll);
      chk("rdata_wf", rd_wf, m_rd_wf);
      chk("rdata_ro", rd_ro, m_rd_ro);
   endtask

   task automatic idle();
      w_v_i = 0; r_v_i = 0; w_addr_i = '0; r_addr_i = '0; w_mask_i = '0; w_data_i = '0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
      w_v_i = 1; w_addr_i = a; w_data_i = d; w_mask_i = m;
   endtask

   task automatic rd(input logic [3:0] a);
      r_v_i = 1; r_addr_i = a;
   endtask

   initial begin
      int n;
      m_ready = 0; m_left = 16; m_rd_wf = '0; m_rd_ro = '0; m_coll = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
      reset_i = 1; idle();
      repeat (3) cyc();
      chk("reset_rdata", rd_wf, 32'h0);
      chk("reset_done", done_wf, 1'b0);

      // Fill phase with traffic that must be ignored.
      reset_i = 0;
      for (int i = 0; i < 15; i++) begin
         wr(4'(i), $urandom, 4'hF); rd(4'(i));
         cyc();
      end
      idle(); cyc();
      chk("init_done_at_16", done_wf, 1'b1);

      for (int a = 0; a < 16; a++) begin
         idle(); rd(4'(a)); cyc();
         chk("init_zero", rd_wf, 32'h0);
      end

      idle(); wr(4'd3, 32'hAABBCCDD, 4'hF); cyc();
      idle(); wr(4'd3, 32'h11223344, 4'b0101); cyc();
      idle(); rd(4'd3); cyc();
      chk("lane_mask", rd_wf, 32'hAA22CC44);

      idle(); wr(4'd5, 32'h12345678, 4'hF); cyc();
      idle(); wr(4'd5, 32'hFFFFFFFF, 4'b0011); rd(4'd5); cyc();
      chk("fwd_wf", rd_wf, 32'h1234FFFF);
      chk("old_ro", rd_ro, 32'h12345678);
      chk("coll_pulse_wf", coll_wf, 1'b1);
      chk("coll_pulse_ro", coll_ro, 1'b1);
      idle(); cyc();
      chk("coll_drop", coll_wf, 1'b0);
      idle(); rd(4'd5); cyc();
      chk("ro_after", rd_ro, 32'h1234FFFF);

      idle(); wr(4'd2, 32'h0000BEEF, 4'hF); cyc();
      idle(); rd(4'd2); cyc();
      for (int i = 0; i < 5; i++) begin
         idle(); wr(4'd2, $urandom, 4'hF); cyc();
         chk("hold_wf", rd_wf, 32'h0000BEEF);
         chk("hold_ro", rd_ro, 32'h0000BEEF);
      end

      // Reset in READY, then again partway through the fill.
      idle(); reset_i = 1; cyc();
      reset_i = 0; repeat (7) cyc();
      reset_i = 1; repeat (2) cyc();
      reset_i = 0;
      n = 0;
      while (!done_wf && n < 40) begin
         cyc(); n++;
      end
      chk("init_restart_latency", n, 16);
      for (int a = 0; a < 16; a++) begin
         idle(); rd(4'(a)); cyc();
         chk("restart_zero", rd_ro, 32'h0);
      end

      // Narrow address range to provoke frequent collisions.
      for (int i = 0; i < 400; i++) begin
         w_v_i = 1'($urandom_range(0, 1));
         r_v_i = 1'($urandom_range(0, 1));
         w_addr_i = 4'($urandom_range(0, 3));
         r_addr_i = 4'($urandom_range(0, 3));
         w_mask_i = 4'($urandom_range(0, 15));
         w_data_i = $urandom;
         cyc();
      end
      idle(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
